// File: rtl/rc4_ksa_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_ksa_fsm
//  Function : RC4 key-scheduling FSM that permutes the shared S RAM in place.
//             Macro RC4_KSA_INIT_EN compiles in the identity-fill phase.
//  Revision : 1.0  initial release
// ============================================================================
module rc4_ksa_fsm #(
    parameter int KEY_LENGTH = 3
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] key,
    input  logic [7:0]              s_q,
    output logic                    busy,
    output logic                    finish,
    output logic                    s_wren,
    output logic [7:0]              address,
    output logic [7:0]              data
);

    localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LENGTH - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_I_ADDR = 4'd1,
        RD_I      = 4'd2,
        CALC_J    = 4'd3,
        RD_J_ADDR = 4'd4,
        RD_J      = 4'd5,
        WR_I      = 4'd6,
        WR_J      = 4'd7,
        NEXT      = 4'd8,
        DONE      = 4'd9
`ifdef RC4_KSA_INIT_EN
        ,
        INIT_WR   = 4'd10
`endif
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [7:0]                i;
    logic [7:0]                i_next;
    logic [7:0]                j;
    logic [7:0]                j_next;
    logic [7:0]                si;
    logic [7:0]                si_next;
    logic [7:0]                sj;
    logic [7:0]                sj_next;
    logic [KIDX_W-1:0]         kidx;
    logic [KIDX_W-1:0]         kidx_next;
    logic [8*KEY_LENGTH-1:0]   key_r;
    logic [8*KEY_LENGTH-1:0]   key_r_next;
    logic [7:0]                key_byte;

    // Byte 0 sits in the most significant byte of the key word.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LENGTH; k++) begin
            if (kidx == KIDX_W'(k)) begin
                key_byte = key_r[8*(KEY_LENGTH-k)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
            key_r <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
            j     <= j_next;
            si    <= si_next;
            sj    <= sj_next;
            kidx  <= kidx_next;
            key_r <= key_r_next;
        end
    end

    always_comb begin
        state_next = state;
        i_next     = i;
        j_next     = j;
        si_next    = si;
        sj_next    = sj;
        kidx_next  = kidx;
        key_r_next = key_r;
        address    = i;
        data       = '0;
        s_wren     = 1'b0;
        finish     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    key_r_next = key;
                    i_next     = '0;
                    j_next     = '0;
                    kidx_next  = '0;
`ifdef RC4_KSA_INIT_EN
                    state_next = INIT_WR;
`else
                    state_next = RD_I_ADDR;
`endif
                end
            end
`ifdef RC4_KSA_INIT_EN
            INIT_WR: begin
                address = i;
                data    = i;
                s_wren  = 1'b1;
                i_next  = i + 8'd1;
                if (i == 8'd255) begin
                    i_next     = '0;
                    state_next = RD_I_ADDR;
                end
            end
`endif
            RD_I_ADDR: begin
                address    = i;
                state_next = RD_I;
            end
            // Synchronous RAM: data for the address held since RD_I_ADDR is valid now.
            RD_I: begin
                address    = i;
                si_next    = s_q;
                state_next = CALC_J;
            end
            CALC_J: begin
                j_next     = j + si + key_byte;
                state_next = RD_J_ADDR;
            end
            RD_J_ADDR: begin
                address    = j;
                state_next = RD_J;
            end
            RD_J: begin
                address    = j;
                sj_next    = s_q;
                state_next = WR_I;
            end
            // When i==j both writes carry the same original byte, so no special case.
            WR_I: begin
                address    = i;
                data       = sj;
                s_wren     = 1'b1;
                state_next = WR_J;
            end
            WR_J: begin
                address    = j;
                data       = si;
                s_wren     = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                i_next    = i + 8'd1;
                kidx_next = (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
                if (i == 8'd255) begin
                    state_next = DONE;
                end else begin
                    state_next = RD_I_ADDR;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire
